// File: rtl/pcdn8_pkg.sv
// rtl/pcdn8_pkg.sv - shared width default, count type and one-shot FSM states for pcdn8_reload
package pcdn8_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pcdn8_state_e;
endpackage

// File: rtl/pcdn8_shadow.sv
// rtl/pcdn8_shadow.sv - double-buffered reload register: pending value promoted to active on xfer
module pcdn8_shadow
  import pcdn8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload_we,
  input  logic [WIDTH-1:0] reload_in,
  input  logic             xfer,
  output logic [WIDTH-1:0] reload_q
);

  logic [WIDTH-1:0] pend;
  logic             pend_v;

  // A write coinciding with a transfer promotes the old pending value and keeps the new one pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_v   <= 1'b0;
      reload_q <= '0;
    end else begin
      if (xfer && pend_v) begin
        reload_q <= pend;
      end
      if (reload_we) begin
        pend   <= reload_in;
        pend_v <= 1'b1;
      end else if (xfer) begin
        pend_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcdn8_reload.sv
// rtl/pcdn8_reload.sv - 8-bit down-counter with load, hold and reload-on-borrow.
// Optional one-shot mode selected by macro PCDN8_ONESHOT_EN.
module pcdn8_reload
  import pcdn8_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             hold,
  input  logic             reload_we,
  input  logic [WIDTH-1:0] reload_in,
  output logic [WIDTH-1:0] count,
  output logic             borrow,
  output logic             zero,
  output logic [WIDTH-1:0] reload_q,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic             step;
  logic             active;
  logic             cnt_step;
  logic             xfer;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] count_next;

  assign step     = en & ~hold & ~load;
  assign cnt_step = step & active;
  assign borrow   = cnt_step & (count == '0);

`ifdef PCDN8_ONESHOT_EN
  pcdn8_state_e state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (load) begin
      state_next = RUN;
    end else if (borrow) begin
      state_next = IDLE;
    end
  end

  // A one-shot terminal count parks at zero; the shadow only advances on load.
  assign active   = (state == RUN);
  assign busy     = active;
  assign xfer     = load;
  assign wrap_val = '0;
`else
  assign active   = 1'b1;
  assign busy     = 1'b1;
  assign xfer     = load | borrow;
  assign wrap_val = reload_q;
`endif

  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_val;
    end else if (cnt_step && (count != '0)) begin
      count_next = count - ONE;
    end else if (borrow) begin
      count_next = wrap_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_next;
      zero  <= (count_next == '0);
    end
  end

  pcdn8_shadow #(
    .WIDTH(WIDTH)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .reload_we(reload_we),
    .reload_in(reload_in),
    .xfer     (xfer),
    .reload_q (reload_q)
  );

endmodule

// File: tb/tb_pcdn8_reload.sv
// tb/tb_pcdn8_reload.sv - self-checking bench for pcdn8_reload: vector table, corner sequences, random vs model
module tb_pcdn8_reload;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       hold;
  logic       reload_we;
  logic [7:0] reload_in;
  logic [7:0] count;
  logic       borrow;
  logic       zero;
  logic [7:0] reload_q;
  logic       busy;

  pcdn8_reload #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .hold     (hold),
    .reload_we(reload_we),
    .reload_in(reload_in),
    .count    (count),
    .borrow   (borrow),
    .zero     (zero),
    .reload_q (reload_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: plain integers following the counter's rules
  int m_count, m_reload, m_pend;
  bit m_pend_v, m_run;
  bit last_borrow;

`ifdef PCDN8_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_pend   = 0;
    m_pend_v = 0;
    m_run    = 0;
  endtask

  // Called at posedge+1; samples borrow mid-cycle, advances the model, checks state after the edge.
  task automatic cycle(input bit l, input int lv, input bit e, input bit h, input bit w, input int ri);
    bit exp_b, do_step, xfer;
    load = l; load_val = lv[7:0]; en = e; hold = h; reload_we = w; reload_in = ri[7:0];
    #4;
    do_step = e && !h && !l;
    if (ONESHOT) exp_b = do_step && m_run && (m_count == 0);
    else         exp_b = do_step && (m_count == 0);
    last_borrow = borrow;
    chk("mdl_borrow", borrow, exp_b);
    if (ONESHOT) begin
      xfer = l;
      if (l) begin
        m_count = lv % 256;
        m_run = 1;
      end else if (do_step && m_run) begin
        if (m_count == 0) m_run = 0;
        else m_count = m_count - 1;
      end
    end else begin
      xfer = l || exp_b;
      if (l) m_count = lv % 256;
      else if (do_step) m_count = (m_count == 0) ? m_reload : m_count - 1;
    end
    if (xfer && m_pend_v) m_reload = m_pend;
    if (w) begin
      m_pend = ri % 256;
      m_pend_v = 1;
    end else if (xfer) begin
      m_pend_v = 0;
    end
    @(posedge clk);
    #1;
    chk("mdl_count", count, m_count);
    chk("mdl_zero", zero, m_count == 0);
    chk("mdl_reload_q", reload_q, m_reload);
    chk("mdl_busy", busy, ONESHOT ? m_run : 1);
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit l;
    int lv;
    bit e;
    bit w;
    int ri;
    bit exp_b;
    int exp_cnt;
  } vec_t;

  vec_t vt[$];

  initial begin
    rst = 1'b1;
    load = 0; load_val = 0; en = 0; hold = 0; reload_we = 0; reload_in = 0;
    model_reset();
    #12;
    chk("rst_count", count, 0);
    chk("rst_zero", zero, 1);
    chk("rst_reload_q", reload_q, 0);
    chk("rst_busy", busy, ONESHOT ? 0 : 1);
    chk("rst_borrow", borrow, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef PCDN8_ONESHOT_EN
    // reload_q == 0 with continuous step: borrow every cycle, count pinned at 0
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      chk("r0_borrow", last_borrow, 1);
      chk("r0_count", count, 0);
    end

    // Load 5 with reload 3 pending, then free-run
    vt.push_back('{0, 0,    0, 1, 3, 0, 0});
    vt.push_back('{1, 5,    1, 0, 0, 0, 5});
    vt.push_back('{0, 0,    1, 0, 0, 0, 4});
    vt.push_back('{0, 0,    1, 0, 0, 0, 3});
    vt.push_back('{0, 0,    1, 0, 0, 0, 2});
    vt.push_back('{0, 0,    1, 0, 0, 0, 1});
    vt.push_back('{0, 0,    1, 0, 0, 0, 0});
    vt.push_back('{0, 0,    1, 0, 0, 1, 3});
    vt.push_back('{0, 0,    1, 0, 0, 0, 2});
    vt.push_back('{0, 0,    1, 0, 0, 0, 1});
    vt.push_back('{0, 0,    1, 0, 0, 0, 0});
    vt.push_back('{0, 0,    1, 0, 0, 1, 3});
    foreach (vt[i]) begin
      cycle(vt[i].l, vt[i].lv, vt[i].e, 0, vt[i].w, vt[i].ri);
      chk($sformatf("vec%0d_borrow", i), last_borrow, vt[i].exp_b);
      chk($sformatf("vec%0d_count", i), count, vt[i].exp_cnt);
    end
`endif

    // Hold overrides enable
    cycle(1, 8'h80, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 1, 0, 0);
      chk("hold_borrow", last_borrow, 0);
      chk("hold_count", count, 8'h80);
    end
    cycle(0, 0, 1, 0, 0, 0);
    chk("hold_release", count, 8'h7F);

    // Load at count 0 with enable: load wins, no borrow
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 8'hAA, 1, 0, 0, 0);
    chk("ldz_borrow", last_borrow, 0);
    chk("ldz_count", count, 8'hAA);

`ifndef PCDN8_ONESHOT_EN
    // Mid-period reload write takes effect one wrap later
    cycle(0, 0, 0, 0, 1, 2);
    cycle(1, 3, 0, 0, 0, 0);
    chk("sh_active", reload_q, 2);
    cycle(0, 0, 1, 0, 1, 8'h10);
    for (int wrap = 0; wrap < 2; wrap++) begin
      int n = 0;
      last_borrow = 0;
      while (!last_borrow && n < 40) begin
        cycle(0, 0, 1, 0, 0, 0);
        n++;
      end
      chk("sh_wrap_seen", last_borrow, 1);
      chk($sformatf("sh_wrap%0d_count", wrap), count, wrap == 0 ? 2 : 8'h10);
    end
`else
    // One-shot: single borrow, parks at 0, then idle
    cycle(1, 2, 1, 0, 0, 0);
    chk("os_busy", busy, 1);
    cycle(0, 0, 1, 0, 0, 0);
    chk("os_c1", count, 1);
    cycle(0, 0, 1, 0, 0, 0);
    chk("os_c0", count, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("os_borrow", last_borrow, 1);
    chk("os_park", count, 0);
    chk("os_idle", busy, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0, 0);
      chk("os_after_borrow", last_borrow, 0);
      chk("os_after_count", count, 0);
    end
`endif

    // Asynchronous reset mid-count
    cycle(1, 8'h40, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0, 0);
    chk("ar_pre", count, 8'h37);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_zero", zero, 1);
    chk("ar_reload_q", reload_q, 0);
    model_reset();
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 12),
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
